// File: rtl/multi_ch_signal_expansioner.sv
// Multi-channel signal expansioner.
// Each channel independently stretches its input line, either as a fixed-width
// edge-triggered pulse with optional retrigger and hold-off (MODE=0) or as a
// trailing-edge extension that follows the input level (MODE=1).
module multi_ch_signal_expansioner #(
    parameter int CH_NUM               = 4,
    parameter int MAX_EXTEND_LEN_WIDTH = 5,
    parameter int HOLDOFF_LEN_WIDTH    = 4
) (
    input  logic                                   CLK,
    input  logic                                   RESETN,
    input  logic                                   MODE,
    input  logic                                   RETRIGGER,
    input  logic [HOLDOFF_LEN_WIDTH-1:0]           HOLDOFF_LEN,
    input  logic [CH_NUM*MAX_EXTEND_LEN_WIDTH-1:0] EXTEND_LEN,
    input  logic [CH_NUM-1:0]                      SIG_IN,
    output logic [CH_NUM-1:0]                      SIG_OUT,
    output logic                                   BUSY
);

    // One counter width serves both the stretch length and the hold-off length.
    localparam int CNT_W = (MAX_EXTEND_LEN_WIDTH > HOLDOFF_LEN_WIDTH) ?
                           MAX_EXTEND_LEN_WIDTH : HOLDOFF_LEN_WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t            state_q [CH_NUM];
    state_t            state_d [CH_NUM];
    logic [CNT_W-1:0]  cnt_q   [CH_NUM];
    logic [CNT_W-1:0]  cnt_d   [CH_NUM];
    logic [CNT_W-1:0]  ext_len [CH_NUM];
    logic [CNT_W-1:0]  ho_len;
    logic [CH_NUM-1:0] prev_q, prev_d;
    logic [CH_NUM-1:0] out_q, out_d;
    logic [CH_NUM-1:0] rise, fall;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              mode_change;

    // Per-channel extend lengths widened to the shared counter width.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_len
        assign ext_len[c] = CNT_W'(EXTEND_LEN[c*MAX_EXTEND_LEN_WIDTH +: MAX_EXTEND_LEN_WIDTH]);
    end

    assign ho_len      = CNT_W'(HOLDOFF_LEN);
    assign rise        = SIG_IN & ~prev_q;
    assign fall        = ~SIG_IN & prev_q;
    assign mode_change = (MODE != mode_q);
    assign prev_d      = SIG_IN;
    assign mode_d      = MODE;

    // Next-state, counter and output logic for every channel plus the busy flag.
    always_comb begin
        busy_d = 1'b0;
        out_d  = out_q;
        for (int c = 0; c < CH_NUM; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            busy_d     = busy_d | (state_q[c] != IDLE);
            if (mode_change) begin
                state_d[c] = IDLE;
                cnt_d[c]   = CNT_ZERO;
                out_d[c]   = 1'b0;
            end else if (!mode_q) begin
                case (state_q[c])
                    IDLE: begin
                        out_d[c] = 1'b0;
                        if (rise[c] && (ext_len[c] != CNT_ZERO)) begin
                            state_d[c] = STRETCH;
                            cnt_d[c]   = ext_len[c] - CNT_ONE;
                            out_d[c]   = 1'b1;
                        end
                    end
                    STRETCH: begin
                        if (RETRIGGER && rise[c] && (ext_len[c] != CNT_ZERO)) begin
                            cnt_d[c] = ext_len[c] - CNT_ONE;
                            out_d[c] = 1'b1;
                        end else if (cnt_q[c] == CNT_ZERO) begin
                            out_d[c] = 1'b0;
                            if (ho_len != CNT_ZERO) begin
                                state_d[c] = HOLDOFF;
                                cnt_d[c]   = ho_len - CNT_ONE;
                            end else begin
                                state_d[c] = IDLE;
                            end
                        end else begin
                            cnt_d[c] = cnt_q[c] - CNT_ONE;
                            out_d[c] = 1'b1;
                        end
                    end
                    HOLDOFF: begin
                        out_d[c] = 1'b0;
                        if (cnt_q[c] == CNT_ZERO) begin
                            state_d[c] = IDLE;
                        end else begin
                            cnt_d[c] = cnt_q[c] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[c] = IDLE;
                        out_d[c]   = 1'b0;
                    end
                endcase
            end else begin
                if (SIG_IN[c]) begin
                    state_d[c] = STRETCH;
                    cnt_d[c]   = ext_len[c];
                    out_d[c]   = 1'b1;
                end else if (state_q[c] == STRETCH) begin
                    if (fall[c]) begin
                        if (ext_len[c] == CNT_ZERO) begin
                            state_d[c] = IDLE;
                            out_d[c]   = 1'b0;
                        end else begin
                            cnt_d[c] = ext_len[c] - CNT_ONE;
                            out_d[c] = 1'b1;
                        end
                    end else if (cnt_q[c] == CNT_ZERO) begin
                        state_d[c] = IDLE;
                        out_d[c]   = 1'b0;
                    end else begin
                        cnt_d[c] = cnt_q[c] - CNT_ONE;
                        out_d[c] = 1'b1;
                    end
                end else begin
                    state_d[c] = IDLE;
                    out_d[c]   = 1'b0;
                end
            end
        end
    end

    // State, counter, edge-history and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int c = 0; c < CH_NUM; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= CNT_ZERO;
            end
            prev_q <= '0;
            out_q  <= '0;
            mode_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            prev_q <= prev_d;
            out_q  <= out_d;
            mode_q <= mode_d;
            busy_q <= busy_d;
        end
    end

    assign SIG_OUT = out_q;
    assign BUSY    = busy_q;

endmodule
